// File: rtl/dryer_cycle_ctrl.sv
// Dryer program sequencer: loads a program from the dial, times it in segments
// (prescaler -> seconds -> segments), then runs an optional cool-down phase.
module dryer_cycle_ctrl #(
  parameter int CLK_PER_SEC = 50000,
  parameter int SEG_SEC     = 900,
  parameter int COOL_SEGS   = 1,
  parameter int HEAT_W      = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ON,
  input  logic              OFF,
  input  logic              PAUSE,
  input  logic              DOOR_OPEN,
  input  logic [3:0]        mainDial,
  input  logic [HEAT_W-1:0] heatDial,
  output logic              MTR,
  output logic [HEAT_W-1:0] HTR,
  output logic [2:0]        SEGS,
  output logic              DONE
);

  localparam int PRE_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int SEC_W = (SEG_SEC > 1) ? $clog2(SEG_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(SEG_SEC - 1);
  localparam logic [2:0]       COOL_N  = 3'(COOL_SEGS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, COOL} state_t;

  state_t            state_q, state_d;
  logic              resume_cool_q, resume_cool_d;
  logic [2:0]        segs_q, segs_d;
  logic [HEAT_W-1:0] lvl_q, lvl_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic              pause_q;
  logic              mtr_q, mtr_d;
  logic [HEAT_W-1:0] htr_q, htr_d;
  logic              done_q, done_d;

  logic              prog_ok;
  logic [2:0]        prog_segs;
  logic [HEAT_W-1:0] prog_lvl;
  logic              running, sec_tick, seg_tick, pause_edge;
  state_t            tick_state;
  logic [2:0]        tick_segs;
  logic              tick_done;

  always_comb begin
    prog_ok   = 1'b1;
    prog_segs = 3'd0;
    prog_lvl  = '0;
    case (mainDial)
      4'h1: begin prog_segs = 3'd5; prog_lvl = HEAT_W'(2'b01); end
      4'h2: begin prog_segs = 3'd5; prog_lvl = HEAT_W'(2'b11); end
      4'h4: begin prog_segs = 3'd2; prog_lvl = '0; end
      4'h8: begin prog_segs = 3'd1; prog_lvl = HEAT_W'(2'b01); end
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: begin
        prog_segs = 3'(mainDial - 4'd9);
        prog_lvl  = heatDial;
      end
      default: prog_ok = 1'b0;
    endcase
  end

  assign running    = (state_q == RUN) || (state_q == COOL);
  assign sec_tick   = running && (pre_q == PRE_MAX);
  assign seg_tick   = sec_tick && (sec_q == SEC_MAX);
  assign pause_edge = PAUSE && !pause_q;

  always_comb begin
    tick_state = state_q;
    tick_segs  = segs_q;
    tick_done  = 1'b0;
    if (seg_tick) begin
      if (segs_q > 3'd1) begin
        tick_segs = segs_q - 3'd1;
      end else if ((state_q == RUN) && (COOL_N != 3'd0)) begin
        tick_state = COOL;
        tick_segs  = COOL_N;
      end else begin
        tick_state = IDLE;
        tick_segs  = 3'd0;
        tick_done  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    resume_cool_d = resume_cool_q;
    segs_d        = segs_q;
    lvl_d         = lvl_q;
    pre_d         = pre_q;
    sec_d         = sec_q;
    done_d        = 1'b0;

    // Time in RUN/COOL always counts, including the edge that leaves for PAUSED.
    if (running) begin
      pre_d = sec_tick ? '0 : pre_q + PRE_W'(1);
      if (sec_tick) sec_d = seg_tick ? '0 : sec_q + SEC_W'(1);
    end

    if (OFF) begin
      state_d       = IDLE;
      resume_cool_d = 1'b0;
      segs_d        = 3'd0;
      pre_d         = '0;
      sec_d         = '0;
    end else if ((DOOR_OPEN || pause_edge) && running) begin
      // A segment ending on the pause edge is booked into the resume target;
      // a finished program completes rather than parking in PAUSED.
      if (tick_done) begin
        state_d = IDLE;
        segs_d  = 3'd0;
        done_d  = 1'b1;
      end else begin
        state_d       = PAUSED;
        resume_cool_d = (tick_state == COOL);
        segs_d        = tick_segs;
      end
    end else if (DOOR_OPEN) begin
      state_d = state_q;
    end else if ((pause_edge || ON) && (state_q == PAUSED)) begin
      state_d = resume_cool_q ? COOL : RUN;
    end else if (ON && prog_ok) begin
      state_d       = RUN;
      resume_cool_d = 1'b0;
      segs_d        = prog_segs;
      lvl_d         = prog_lvl;
      pre_d         = '0;
      sec_d         = '0;
    end else begin
      state_d = tick_state;
      segs_d  = tick_segs;
      done_d  = tick_done;
    end

    mtr_d = (state_d == RUN) || (state_d == COOL);
    htr_d = (state_d == RUN) ? lvl_d : '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      resume_cool_q <= 1'b0;
      segs_q        <= 3'd0;
      lvl_q         <= '0;
      pre_q         <= '0;
      sec_q         <= '0;
      pause_q       <= 1'b0;
      mtr_q         <= 1'b0;
      htr_q         <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      resume_cool_q <= resume_cool_d;
      segs_q        <= segs_d;
      lvl_q         <= lvl_d;
      pre_q         <= pre_d;
      sec_q         <= sec_d;
      pause_q       <= PAUSE;
      mtr_q         <= mtr_d;
      htr_q         <= htr_d;
      done_q        <= done_d;
    end
  end

  assign MTR  = mtr_q;
  assign HTR  = htr_q;
  assign SEGS = segs_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_dryer_cycle_ctrl.sv
// Directed bench for dryer_cycle_ctrl with a 12-cycle segment (4 clk/s, 3 s/seg).
module tb_dryer_cycle_ctrl;

  logic       CLK = 1'b0;
  logic       RESET, ON, OFF, PAUSE, DOOR_OPEN;
  logic [3:0] mainDial;
  logic [1:0] heatDial;
  logic       MTR;
  logic [1:0] HTR;
  logic [2:0] SEGS;
  logic       DONE;

  int checks = 0;
  int errors = 0;

  dryer_cycle_ctrl #(
    .CLK_PER_SEC(4),
    .SEG_SEC(3),
    .COOL_SEGS(1),
    .HEAT_W(2)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .ON(ON),
    .OFF(OFF),
    .PAUSE(PAUSE),
    .DOOR_OPEN(DOOR_OPEN),
    .mainDial(mainDial),
    .heatDial(heatDial),
    .MTR(MTR),
    .HTR(HTR),
    .SEGS(SEGS),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Snapshot layout: {MTR, HTR[1:0], SEGS[2:0], DONE}
  function automatic logic [6:0] snap();
    return {MTR, HTR, SEGS, DONE};
  endfunction

  // Returns negedges elapsed until DONE is seen, or -1 when the budget expires.
  task automatic run_until_done(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (DONE !== 1'b0) n++;
    end
  endtask

  task automatic load(input logic [3:0] dial, input logic [1:0] heat);
    mainDial = dial;
    heatDial = heat;
    ON = 1'b1;
    @(negedge CLK);
    ON = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; ON = 1'b1; mainDial = 4'h1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (snap() !== 7'b0_00_000_0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %b expected %b", i, snap(), 7'b0_00_000_0);
      end
    end
    RESET = 1'b0; ON = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_normal();
    int n;
    load(4'h1, 2'b00);
    checks++;
    if (snap() !== 7'b1_01_101_0) begin errors++; $display("FAIL normal_load: got %b expected %b", snap(), 7'b1_01_101_0); end
    repeat (59) @(negedge CLK);
    checks++;
    if (snap() !== 7'b1_01_001_0) begin errors++; $display("FAIL normal_last_run: got %b expected %b", snap(), 7'b1_01_001_0); end
    @(negedge CLK);
    checks++;
    if (snap() !== 7'b1_00_001_0) begin errors++; $display("FAIL normal_cool: got %b expected %b", snap(), 7'b1_00_001_0); end
    run_until_done(20, n);
    checks++;
    if (n !== 12) begin errors++; $display("FAIL normal_done_time: got %0d expected %0d", n, 12); end
    checks++;
    if (snap() !== 7'b0_00_000_1) begin errors++; $display("FAIL normal_done_out: got %b expected %b", snap(), 7'b0_00_000_1); end
    @(negedge CLK);
    checks++;
    if (snap() !== 7'b0_00_000_0) begin errors++; $display("FAIL normal_done_pulse: got %b expected %b", snap(), 7'b0_00_000_0); end
  endtask

  task automatic test_manual();
    int n;
    load(4'hD, 2'b10);
    checks++;
    if (snap() !== 7'b1_10_100_0) begin errors++; $display("FAIL manual_load: got %b expected %b", snap(), 7'b1_10_100_0); end
    repeat (48) @(negedge CLK);
    checks++;
    if (snap() !== 7'b1_00_001_0) begin errors++; $display("FAIL manual_cool: got %b expected %b", snap(), 7'b1_00_001_0); end
    run_until_done(20, n);
    checks++;
    if (n !== 12) begin errors++; $display("FAIL manual_done_time: got %0d expected %0d", n, 12); end
  endtask

  task automatic test_pause();
    int n;
    load(4'h1, 2'b00);
    repeat (19) @(negedge CLK);
    PAUSE = 1'b1;
    @(negedge CLK);
    checks++;
    if (snap() !== 7'b0_00_100_0) begin errors++; $display("FAIL pause_enter: got %b expected %b", snap(), 7'b0_00_100_0); end
    repeat (5) @(negedge CLK);
    PAUSE = 1'b0;
    repeat (24) @(negedge CLK);
    checks++;
    if (snap() !== 7'b0_00_100_0) begin errors++; $display("FAIL pause_held: got %b expected %b", snap(), 7'b0_00_100_0); end
    ON = 1'b1;
    @(negedge CLK);
    ON = 1'b0;
    checks++;
    if (snap() !== 7'b1_01_100_0) begin errors++; $display("FAIL pause_resume: got %b expected %b", snap(), 7'b1_01_100_0); end
    run_until_done(80, n);
    checks++;
    if (n !== 52) begin errors++; $display("FAIL pause_done_time: got %0d expected %0d", n, 52); end
  endtask

  task automatic test_door_cool();
    int n;
    load(4'h8, 2'b00);
    checks++;
    if (snap() !== 7'b1_01_001_0) begin errors++; $display("FAIL door_load: got %b expected %b", snap(), 7'b1_01_001_0); end
    repeat (12) @(negedge CLK);
    checks++;
    if (snap() !== 7'b1_00_001_0) begin errors++; $display("FAIL door_cool: got %b expected %b", snap(), 7'b1_00_001_0); end
    repeat (2) @(negedge CLK);
    DOOR_OPEN = 1'b1;
    @(negedge CLK);
    checks++;
    if (snap() !== 7'b0_00_001_0) begin errors++; $display("FAIL door_pause: got %b expected %b", snap(), 7'b0_00_001_0); end
    ON = 1'b1; PAUSE = 1'b1;
    @(negedge CLK);
    ON = 1'b0; PAUSE = 1'b0;
    checks++;
    if (snap() !== 7'b0_00_001_0) begin errors++; $display("FAIL door_blocks_resume: got %b expected %b", snap(), 7'b0_00_001_0); end
    @(negedge CLK);
    DOOR_OPEN = 1'b0;
    @(negedge CLK);
    checks++;
    if (snap() !== 7'b0_00_001_0) begin errors++; $display("FAIL door_closed_hold: got %b expected %b", snap(), 7'b0_00_001_0); end
    ON = 1'b1;
    @(negedge CLK);
    ON = 1'b0;
    checks++;
    if (snap() !== 7'b1_00_001_0) begin errors++; $display("FAIL door_resume_cool: got %b expected %b", snap(), 7'b1_00_001_0); end
    run_until_done(20, n);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL door_done_time: got %0d expected %0d", n, 9); end
  endtask

  task automatic test_back_to_back();
    int n;
    load(4'h1, 2'b00);
    repeat (30) @(negedge CLK);
    load(4'h4, 2'b11);
    checks++;
    if (snap() !== 7'b1_00_010_0) begin errors++; $display("FAIL reload_out: got %b expected %b", snap(), 7'b1_00_010_0); end
    run_until_done(50, n);
    checks++;
    if (n !== 36) begin errors++; $display("FAIL reload_done_time: got %0d expected %0d", n, 36); end
  endtask

  task automatic test_abort();
    int n;
    load(4'h1, 2'b00);
    repeat (5) @(negedge CLK);
    OFF = 1'b1; ON = 1'b1;
    @(negedge CLK);
    OFF = 1'b0; ON = 1'b0;
    checks++;
    if (snap() !== 7'b0_00_000_0) begin errors++; $display("FAIL off_idle: got %b expected %b", snap(), 7'b0_00_000_0); end
    count_done(80, n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL off_no_done: got %0d expected %0d", n, 0); end
    load(4'h3, 2'b11);
    checks++;
    if (snap() !== 7'b0_00_000_0) begin errors++; $display("FAIL bad_dial: got %b expected %b", snap(), 7'b0_00_000_0); end
    load(4'h2, 2'b00);
    checks++;
    if (snap() !== 7'b1_11_101_0) begin errors++; $display("FAIL dial2_load: got %b expected %b", snap(), 7'b1_11_101_0); end
    repeat (10) @(negedge CLK);
    RESET = 1'b1; ON = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; ON = 1'b0;
    checks++;
    if (snap() !== 7'b0_00_000_0) begin errors++; $display("FAIL reset_mid: got %b expected %b", snap(), 7'b0_00_000_0); end
    count_done(80, n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL reset_no_done: got %0d expected %0d", n, 0); end
  endtask

  initial begin
    RESET = 1'b1; ON = 1'b0; OFF = 1'b0; PAUSE = 1'b0; DOOR_OPEN = 1'b0;
    mainDial = 4'h0; heatDial = 2'b00;
    test_reset();
    test_normal();
    test_manual();
    test_pause();
    test_door_cool();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dryer_cycle_ctrl.md
DRYER_CYCLE_CTRL -- requirements
Module: dryer_cycle_ctrl

Interface
REQ-001 Parameter CLK_PER_SEC, default 50000, meaning clock cycles per second tick (>=2).
REQ-002 Parameter SEG_SEC, default 900, meaning seconds per program segment (>=1).
REQ-003 Parameter COOL_SEGS, default 1, meaning cool-down segments after heat phase (0..7; 0 = no cool-down).
REQ-004 Parameter HEAT_W, default 2, meaning heater level width.
REQ-005 Port CLK  in  1  system clock; sole clock.
REQ-006 Port RESET  in  1  synchronous, active-high reset.
REQ-007 Port ON  in  1  start/resume request, sampled each posedge.
REQ-008 Port OFF  in  1  abort request, sampled each posedge.
REQ-009 Port PAUSE  in  1  pause/resume request, rising-edge detected internally.
REQ-010 Port DOOR_OPEN  in  1  door interlock, level.
REQ-011 Port mainDial  in  4  program select.
REQ-012 Port heatDial  in  HEAT_W  manual heat level.
REQ-013 Port MTR  out  1  drum motor enable, registered.
REQ-014 Port HTR  out  HEAT_W  heater level, registered.
REQ-015 Port SEGS  out  3  segments remaining in current phase, registered.
REQ-016 Port DONE  out  1  one-cycle pulse on normal cycle completion.

Function
REQ-017 States SHALL be IDLE, RUN, PAUSED, COOL.
REQ-018 Program load on ON (from IDLE, RUN or COOL): dial 1 -> 5 segs, HTR 01; dial 2 -> 5 segs, HTR 11; dial 4 -> 2 segs, HTR 00; dial 8 -> 1 seg, HTR 01; dial A..F -> (dial-9) segs (1..6), HTR = heatDial; HEAT_W>2 zero-extends fixed levels.
REQ-019 ON with any other dial value SHALL be ignored (state unchanged).
REQ-020 Program load SHALL enter RUN, set SEGS, clear both timer counters.
REQ-021 Priority per cycle: RESET > OFF > DOOR_OPEN > PAUSE edge > ON > timer expiry.
REQ-022 OFF in any state -> IDLE next cycle, counters cleared, no DONE.
REQ-023 Prescaler counts 0..CLK_PER_SEC-1 only in RUN/COOL; wrap produces sec tick.
REQ-024 Second counter counts 0..SEG_SEC-1 on sec ticks; wrap produces seg tick.
REQ-025 Counters SHALL hold (not clear) in PAUSED; clear on entering IDLE or on program load.
REQ-026 Seg tick in RUN with SEGS>1 -> SEGS-1; with SEGS==1 -> COOL with SEGS=COOL_SEGS, or IDLE+DONE if COOL_SEGS==0.
REQ-027 Seg tick in COOL with SEGS>1 -> SEGS-1; with SEGS==1 -> IDLE, DONE=1 for exactly one cycle.
REQ-028 One segment SHALL last exactly CLK_PER_SEC*SEG_SEC cycles of RUN/COOL time.
REQ-029 DOOR_OPEN high in RUN/COOL -> PAUSED next cycle; resume target (RUN or COOL) retained.
REQ-030 PAUSE edge in RUN/COOL -> PAUSED; PAUSE edge or ON in PAUSED -> retained target, only if DOOR_OPEN low.
REQ-031 ON in PAUSED SHALL resume, not reload the program.
REQ-032 Outputs: IDLE MTR=0 HTR=0; RUN MTR=1 HTR=program level; COOL MTR=1 HTR=0; PAUSED MTR=0 HTR=0; SEGS held in PAUSED, 0 in IDLE.
REQ-033 Outputs SHALL update on the same edge the state changes (one cycle after input sampled).
REQ-034 Counter widths SHALL be $clog2-derived from parameters; no truncation at parameter maxima.

Reset
REQ-035 RESET high at posedge -> IDLE, MTR=0, HTR=0, SEGS=0, DONE=0, all counters and PAUSE edge register cleared.
REQ-036 RESET mid-cycle SHALL abort with no DONE pulse; RESET overrides all inputs in the same cycle.

Verification (CLK_PER_SEC=4, SEG_SEC=3, COOL_SEGS=1; segment = 12 cycles)
REQ-037 RESET 2 cycles, ON=1 same cycles -> MTR=0, HTR=00, SEGS=0, DONE=0 throughout.
REQ-038 dial=1, ON 1 cycle -> next cycle MTR=1 HTR=01 SEGS=5; 60 cycles later MTR=1 HTR=00 SEGS=1; 12 cycles later MTR=0, DONE=1 one cycle.
REQ-039 dial=D, heatDial=10, ON -> SEGS=4, HTR=10; completion after 48+12 cycles.
REQ-040 dial=1 run, PAUSE edge at run cycle 20, held PAUSED 30 cycles, ON -> outputs 0 and SEGS=4 while paused; DONE 30 cycles later than REQ-038.
REQ-041 DOOR_OPEN=1 during COOL -> PAUSED; ON and PAUSE ignored while door open; DOOR_OPEN=0 then ON -> COOL, MTR=1 HTR=00.
REQ-042 OFF and ON same cycle in RUN -> IDLE, no DONE; dial=3 with ON in IDLE -> remains IDLE.
